// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline hazard controller.
//   REG_AW_DEF : default register-address width
//   state_t    : controller state encoding (RUN=0, LOAD_STALL=1, BR_FLUSH=2)
//   FWD_*      : EX-stage operand select codes driven on FwdA / FwdB
//   pipe_ctl_t : bundle of PC / stage-register enables and flushes, with the
//                four presets the controller switches between
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int REG_AW_DEF = 6;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        BR_FLUSH   = 2'd2
    } state_t;

    // EX operand select: register value from ID_EX, ALU result in MEM, WB data
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic pc_sel_br;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } pipe_ctl_t;

    // Normal flow: everything advances, nothing is squashed
    localparam pipe_ctl_t CTL_RUN = '{
        pc_write: 1'b1, if_id_write: 1'b1, pc_sel_br: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, ex_mem_flush: 1'b0
    };

    // Load-use: freeze PC and IF_ID, push a bubble into ID_EX
    localparam pipe_ctl_t CTL_STALL = '{
        pc_write: 1'b0, if_id_write: 1'b0, pc_sel_br: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, ex_mem_flush: 1'b0
    };

    // Taken branch: load the target and squash the three wrong-path stages
    localparam pipe_ctl_t CTL_BRANCH = '{
        pc_write: 1'b1, if_id_write: 1'b1, pc_sel_br: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1
    };

    // Reset: hold the PC and keep every stage register squashed
    localparam pipe_ctl_t CTL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, pc_sel_br: 1'b0,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, ex_mem_flush: 1'b1
    };

endpackage

// File: rtl/fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational operand-forwarding select generation.
//   Inputs : rs_ex_i / rt_ex_i     sources of the instruction in EX
//            rs_id_i / rt_id_i     sources of the instruction in ID
//            rd_mem_i, regwrite_mem_i, memread_mem_i   MEM-stage writer
//            rd_wb_i,  regwrite_wb_i                   WB-stage writer
//   Outputs: fwd_a_o / fwd_b_o     EX operand select (FWD_RF/FWD_MEM/FWD_WB)
//            fwd_id_a_o / fwd_id_b_o  ID read bypass from WB data
// No register address is treated as hardwired zero; every address forwards.
// -----------------------------------------------------------------------------
module fwd_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] rs_ex_i,
    input  logic [REG_AW-1:0] rt_ex_i,
    input  logic [REG_AW-1:0] rs_id_i,
    input  logic [REG_AW-1:0] rt_id_i,
    input  logic [REG_AW-1:0] rd_mem_i,
    input  logic              regwrite_mem_i,
    input  logic              memread_mem_i,
    input  logic [REG_AW-1:0] rd_wb_i,
    input  logic              regwrite_wb_i,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              fwd_id_a_o,
    output logic              fwd_id_b_o
);

    // A load in MEM has no data yet (it is still being read), so only a
    // non-load writer in MEM may forward; the younger MEM writer wins over WB.
    function automatic logic [1:0] ex_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_mem,
        input logic              mem_ok,
        input logic [REG_AW-1:0] rd_wb,
        input logic              wb_ok
    );
        logic [1:0] sel;
        if (mem_ok && (rd_mem == src)) begin
            sel = FWD_MEM;
        end else if (wb_ok && (rd_wb == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    logic mem_ok_s;

    // EX operand selects and ID bypass (writer three instructions ahead)
    always_comb begin
        mem_ok_s   = regwrite_mem_i && !memread_mem_i;
        fwd_a_o    = ex_sel(rs_ex_i, rd_mem_i, mem_ok_s, rd_wb_i, regwrite_wb_i);
        fwd_b_o    = ex_sel(rt_ex_i, rd_mem_i, mem_ok_s, rd_wb_i, regwrite_wb_i);
        fwd_id_a_o = regwrite_wb_i && (rd_wb_i == rs_id_i);
        fwd_id_b_o = regwrite_wb_i && (rd_wb_i == rt_id_i);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard / sequencing controller for a 5-stage pipeline.
//   CLK, RST                     clock, synchronous active-high reset
//   Rs_ID, Rt_ID, Rs/Rt_Used_ID  sources of the instruction in ID
//   Rs_EX, Rt_EX                 sources carried in ID_EX
//   Rd/RegWrite/MemRead_EX       EX-stage writer
//   Rd/RegWrite/MemRead_MEM      MEM-stage writer
//   Rd_WB, RegWrite_WB           WB-stage writer
//   Br_Taken                     taken branch resolved in MEM
//   PC_Write, IF_ID_Write        PC / IF_ID load enables
//   PC_Sel_Br                    select branch target into PC
//   IF_ID/ID_EX/EX_MEM_Flush     squash that stage register on next edge
//   FwdA, FwdB                   EX operand selects (see pipe_pkg FWD_*)
//   FwdID_A, FwdID_B             ID read bypass from WB data
//   Br_Busy                      refill window after a redirect is active
// Outputs are combinational from state and inputs (zero-cycle latency).
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating counters
//   Stall_Cnt (load-use stalls) and Flush_Cnt (branch redirects), CNT_W bits.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW       = REG_AW_DEF,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [REG_AW-1:0] Rs_ID,
    input  logic [REG_AW-1:0] Rt_ID,
    input  logic              Rs_Used_ID,
    input  logic              Rt_Used_ID,
    input  logic [REG_AW-1:0] Rs_EX,
    input  logic [REG_AW-1:0] Rt_EX,
    input  logic [REG_AW-1:0] Rd_EX,
    input  logic              RegWrite_EX,
    input  logic              MemRead_EX,
    input  logic [REG_AW-1:0] Rd_MEM,
    input  logic              RegWrite_MEM,
    input  logic              MemRead_MEM,
    input  logic [REG_AW-1:0] Rd_WB,
    input  logic              RegWrite_WB,
    input  logic              Br_Taken,
    output logic              PC_Write,
    output logic              IF_ID_Write,
    output logic              PC_Sel_Br,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Flush,
    output logic              EX_MEM_Flush,
    output logic [1:0]        FwdA,
    output logic [1:0]        FwdB,
    output logic              FwdID_A,
    output logic              FwdID_B,
    output logic              Br_Busy
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  Stall_Cnt,
    output logic [CNT_W-1:0]  Flush_Cnt
`endif
);

    // The refill counter is 4 bits wide, which bounds the flush window
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 15) || (CNT_W < 1)) begin : g_param_err
        $error("pipe_hazard_ctrl: FLUSH_CYCLES must be 1..15 and CNT_W >= 1");
    end

    localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    state_t     seq_state_s;
    logic [3:0] fl_cnt_q;
    logic [3:0] fl_cnt_d;
    logic [3:0] seq_cnt_s;

    logic       br_go_s;
    logic       lu_s;
    logic       stall_evt_s;
    pipe_ctl_t  ctl_s;
    pipe_ctl_t  ctl_out_s;

    logic [1:0] fwd_a_s;
    logic [1:0] fwd_b_s;
    logic       fwd_id_a_s;
    logic       fwd_id_b_s;
    logic [1:0] fwd_a_out_s;
    logic [1:0] fwd_b_out_s;
    logic       fwd_id_a_out_s;
    logic       fwd_id_b_out_s;
    logic       busy_out_s;

    fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd (
        .rs_ex_i        (Rs_EX),
        .rt_ex_i        (Rt_EX),
        .rs_id_i        (Rs_ID),
        .rt_id_i        (Rt_ID),
        .rd_mem_i       (Rd_MEM),
        .regwrite_mem_i (RegWrite_MEM),
        .memread_mem_i  (MemRead_MEM),
        .rd_wb_i        (Rd_WB),
        .regwrite_wb_i  (RegWrite_WB),
        .fwd_a_o        (fwd_a_s),
        .fwd_b_o        (fwd_b_s),
        .fwd_id_a_o     (fwd_id_a_s),
        .fwd_id_b_o     (fwd_id_b_s)
    );

    // Hazard events: redirect (blocked during refill) and load-use
    always_comb begin
        br_go_s = Br_Taken && (state_q != BR_FLUSH);
        lu_s    = MemRead_EX && RegWrite_EX &&
                  ((Rs_Used_ID && (Rd_EX == Rs_ID)) ||
                   (Rt_Used_ID && (Rd_EX == Rt_ID)));
        // a redirect squashes the stalled instruction, so it is not a stall
        stall_evt_s = lu_s && !br_go_s;
    end

    // Free-running sequencing when no new event arrives
    always_comb begin
        seq_state_s = RUN;
        seq_cnt_s   = 4'd0;
        case (state_q)
            RUN: begin
                seq_state_s = RUN;
                seq_cnt_s   = 4'd0;
            end
            LOAD_STALL: begin
                seq_state_s = RUN;
                seq_cnt_s   = 4'd0;
            end
            BR_FLUSH: begin
                if (fl_cnt_q == 4'd0) begin
                    seq_state_s = RUN;
                    seq_cnt_s   = 4'd0;
                end else begin
                    seq_state_s = BR_FLUSH;
                    seq_cnt_s   = fl_cnt_q - 4'd1;
                end
            end
            default: begin
                seq_state_s = RUN;
                seq_cnt_s   = 4'd0;
            end
        endcase
    end

    // Event priority: branch beats load-use, load-use beats normal flow
    always_comb begin
        state_d  = seq_state_s;
        fl_cnt_d = seq_cnt_s;
        ctl_s    = CTL_RUN;
        if (br_go_s) begin
            ctl_s    = CTL_BRANCH;
            state_d  = BR_FLUSH;
            fl_cnt_d = FL_INIT;
        end else if (lu_s) begin
            ctl_s = CTL_STALL;
            // A stall inside the refill window keeps the window running so a
            // stale Br_Taken from the squashed path stays masked.
            if (state_q == BR_FLUSH) begin
                state_d  = seq_state_s;
                fl_cnt_d = seq_cnt_s;
            end else begin
                state_d  = LOAD_STALL;
                fl_cnt_d = 4'd0;
            end
        end else begin
            ctl_s    = CTL_RUN;
            state_d  = seq_state_s;
            fl_cnt_d = seq_cnt_s;
        end
    end

    // State and refill counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            fl_cnt_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    // Reset overrides every output so the pipe stays squashed while held
    always_comb begin
        ctl_out_s      = CTL_RESET;
        fwd_a_out_s    = FWD_RF;
        fwd_b_out_s    = FWD_RF;
        fwd_id_a_out_s = 1'b0;
        fwd_id_b_out_s = 1'b0;
        busy_out_s     = 1'b0;
        if (RST) begin
            ctl_out_s      = CTL_RESET;
            fwd_a_out_s    = FWD_RF;
            fwd_b_out_s    = FWD_RF;
            fwd_id_a_out_s = 1'b0;
            fwd_id_b_out_s = 1'b0;
            busy_out_s     = 1'b0;
        end else begin
            ctl_out_s      = ctl_s;
            fwd_a_out_s    = fwd_a_s;
            fwd_b_out_s    = fwd_b_s;
            fwd_id_a_out_s = fwd_id_a_s;
            fwd_id_b_out_s = fwd_id_b_s;
            busy_out_s     = (state_q == BR_FLUSH);
        end
    end

    assign PC_Write     = ctl_out_s.pc_write;
    assign IF_ID_Write  = ctl_out_s.if_id_write;
    assign PC_Sel_Br    = ctl_out_s.pc_sel_br;
    assign IF_ID_Flush  = ctl_out_s.if_id_flush;
    assign ID_EX_Flush  = ctl_out_s.id_ex_flush;
    assign EX_MEM_Flush = ctl_out_s.ex_mem_flush;
    assign FwdA         = fwd_a_out_s;
    assign FwdB         = fwd_b_out_s;
    assign FwdID_A      = fwd_id_a_out_s;
    assign FwdID_B      = fwd_id_b_out_s;
    assign Br_Busy      = busy_out_s;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Saturating event counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt_s && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (br_go_s && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;
`else
    // Stall events only feed the optional counters
    logic unused_stall_evt_s;
    assign unused_stall_evt_s = stall_evt_s;
`endif

endmodule
